// File: rtl/alu_result_fifo.sv
// Result FIFO buffering ALU outputs with registered read data and one-cycle read latency.
// Define ALU_FIFO_STATUS_EN to build in the sticky overflow/underflow flags; otherwise they read as 0.
module alu_result_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       rd_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_rdData;
   logic             r_rdValid;

   logic w_full;
   logic w_empty;
   logic w_pushOk;
   logic w_popOk;

   assign w_full  = (r_count == FULL_COUNT);
   assign w_empty = (r_count == '0);

   // A push into a full FIFO is only safe when the same edge frees a slot;
   // a push into an empty FIFO never falls through to the read port.
   assign w_pushOk = wr_en && (!w_full || rd_en);
   assign w_popOk  = rd_en && !w_empty;

   // Storage is not reset; pointers and count alone decide what is visible.
   always_ff @(posedge clock) begin
      if (!reset && w_pushOk) begin
         r_mem[r_wrPtr] <= wr_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_count   <= '0;
         r_rdData  <= '0;
         r_rdValid <= 1'b0;
      end else begin
         r_rdValid <= w_popOk;
         if (w_pushOk) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_popOk) begin
            r_rdData <= r_mem[r_rdPtr];
            r_rdPtr  <= r_rdPtr + PTR_W'(1);
         end
         case ({w_pushOk, w_popOk})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef ALU_FIFO_STATUS_EN
   logic r_overflow;
   logic r_underflow;

   // Sticky error flags: only reset clears them.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (wr_en && !w_pushOk) begin
            r_overflow <= 1'b1;
         end
         if (rd_en && !w_popOk) begin
            r_underflow <= 1'b1;
         end
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

   assign rd_data  = r_rdData;
   assign rd_valid = r_rdValid;
   assign count    = r_count;
   assign full     = w_full;
   assign empty    = w_empty;

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter: WIDTH, 8, data width in bits, matches the 8-bit ALU result.
REQ-002 Parameter: DEPTH, 8, number of entries; SHALL be a power of two; pointer width = log2(DEPTH).
REQ-003 Port: clock  input  1  rising-edge clock; on the board it is driven from KEY[0].
REQ-004 Port: reset  input  1  synchronous, active-high reset; on the board it is driven from SW[9].
REQ-005 Port: wr_en  input  1  push request; sampled on the rising edge of clock.
REQ-006 Port: wr_data  input  WIDTH  value to push; connected to ALUOut.
REQ-007 Port: rd_en  input  1  pop request; sampled on the rising edge of clock.
REQ-008 Port: rd_data  output  WIDTH  registered value of the last popped entry.
REQ-009 Port: rd_valid  output  1  high for exactly one cycle after an accepted pop.
REQ-010 Port: count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 Port: full  output  1  asserted when count == DEPTH.
REQ-012 Port: empty  output  1  asserted when count == 0.
REQ-013 Port: overflow  output  1  sticky flag: a push was dropped.
REQ-014 Port: underflow  output  1  sticky flag: a pop was ignored.

Function
REQ-015 A push SHALL be accepted on an edge where wr_en=1 and full=0, or where wr_en=1, rd_en=1 and full=1. An accepted push writes wr_data at wr_ptr, then wr_ptr increments modulo DEPTH.
REQ-016 A pop SHALL be accepted on an edge where rd_en=1 and empty=0. An accepted pop loads rd_data with the entry at rd_ptr on that edge, sets rd_valid=1 for the next cycle, and increments rd_ptr modulo DEPTH.
REQ-017 Read latency SHALL be one cycle from rd_en sampled high to rd_data/rd_valid updated.
REQ-018 rd_data SHALL hold its value when no pop is accepted; rd_valid SHALL be 0 on any cycle not following an accepted pop.
REQ-019 count SHALL increment on push-only, decrement on pop-only, and stay unchanged on push+pop or on no operation; full and empty SHALL be derived combinationally from count.
REQ-020 Push and pop on the same edge while empty: the push is accepted; the pop is not accepted (no fall-through); count becomes 1; underflow is set.
REQ-021 Push and pop on the same edge while full: both are accepted; the pop returns the oldest entry; count stays DEPTH; overflow is not set.
REQ-022 Push-only while full: the push is dropped, and memory, pointers and count are unchanged.
REQ-023 Pop-only while empty: the pop is ignored, and rd_data and the pointers are unchanged.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 with no gap or loss of ordering; output order SHALL be strict FIFO.

Reset
REQ-025 While reset=1 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
REQ-026 Reset SHALL take priority over wr_en/rd_en on the same edge; no push or pop occurs.
REQ-027 Memory contents need not be cleared; stale entries SHALL never be observable after reset.
REQ-028 Reset asserted mid-stream SHALL discard all entries; the first pop after reset and a push SHALL return the first value pushed after reset.

Configuration
REQ-029 Macro ALU_FIFO_STATUS_EN, when defined, SHALL compile in the sticky flags: overflow is set by a dropped push (REQ-022), underflow by an ignored pop (REQ-020, REQ-023), and both clear only on reset.
REQ-030 Without ALU_FIFO_STATUS_EN, the overflow and underflow ports SHALL remain present, tied to constant 0, with no flag registers; all other behaviour is identical.

Verification
REQ-031 Reset, then push 0x12, 0x34, 0x56 on consecutive edges, then pop three times -> rd_data 0x12, 0x34, 0x56 on successive cycles, each with rd_valid=1; final count=0, empty=1.
REQ-032 Push 0x01..0x08 -> full=1, count=8; push 0xFF -> dropped, overflow=1 (macro defined) or 0 (macro undefined); eight pops return 0x01..0x08 in order.
REQ-033 Fill to 8 entries, then push 0xAA with a simultaneous pop -> pop returns 0x01, count stays 8; after seven more pops, the next pop returns 0xAA.
REQ-034 From empty, push 0x77 and pop on the same edge -> rd_valid=0 the next cycle, count=1, underflow=1 (macro defined); the next pop returns 0x77.
REQ-035 Wrap test: push and pop 20 values 0x00..0x13 with occupancy kept between 1 and 3 -> output order is exact and pointers wrap at least twice.
REQ-036 Push 0x11 and 0x22, then assert reset together with wr_en=1 (wr_data 0x33) -> count=0, rd_data=0, flags=0, 0x33 not stored; then push 0x44 and pop -> rd_data=0x44.
